// File: rtl/mem_port_arbiter.sv
// Arbitrates buffered capture writes and single-line readbacks
// onto one memory command port, one command outstanding at a time.
module mem_port_arbiter #(
  parameter int SAMPLE_PACKET_WIDTH = 32,
  parameter int WBUF_DEPTH          = 4,
  parameter int WR_URGENT           = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           wr_valid,
  input  logic [26:0]                    wr_addr,
  input  logic [SAMPLE_PACKET_WIDTH-1:0] wr_data,
  output logic                           wr_full,
  output logic                           wr_overflow,
  output logic [$clog2(WBUF_DEPTH):0]    wbuf_level,
  input  logic                           rd_req,
  input  logic [26:0]                    rd_addr,
  output logic                           rd_allowed,
  output logic                           has_return_data,
  output logic [127:0]                   return_data,
  input  logic                           get_return_data,
  output logic                           mem_cmd_valid,
  output logic                           mem_cmd_write,
  output logic [26:0]                    mem_cmd_addr,
  output logic [SAMPLE_PACKET_WIDTH-1:0] mem_wdata,
  input  logic                           mem_cmd_ready,
  input  logic                           mem_rd_valid,
  input  logic [127:0]                   mem_rd_data
);
  localparam int AW = $clog2(WBUF_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(WBUF_DEPTH);
  localparam logic [LW-1:0] URG_LVL  = LW'(WR_URGENT);

  typedef enum logic [1:0] {
    IDLE, WR_ISSUE, RD_ISSUE, RD_WAIT
  } state_e;

  state_e                         state_q;
  logic [26:0]                    fa_q [WBUF_DEPTH];
  logic [SAMPLE_PACKET_WIDTH-1:0] fd_q [WBUF_DEPTH];
  logic [AW-1:0]                  wptr_q, rptr_q;
  logic [LW-1:0]                  level_q, level_d;
  logic                           ovf_q, last_wr_q;
  logic                           rd_allowed_q, has_q;
  logic                           valid_q, write_q;
  logic [26:0]                    addr_q;
  logic [SAMPLE_PACKET_WIDTH-1:0] wdata_q;
  logic [127:0]                   ret_q;
  logic                           full, pop, push;
  logic                           go_rd, go_wr;

  assign full    = level_q == FULL_LVL;
  assign pop     = (state_q == WR_ISSUE) && mem_cmd_ready;
  // A pop in the same cycle frees the slot, so a push at full still lands.
  assign push    = wr_valid && (!full || pop);
  assign level_d = level_q + LW'(push) - LW'(pop);

  assign go_rd = !(level_q >= URG_LVL) && rd_req && !has_q &&
                 (level_q == '0 || last_wr_q);
  assign go_wr = !go_rd && (level_q != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      fa_q[wptr_q] <= wr_addr;
      fd_q[wptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop) rptr_q <= rptr_q + AW'(1);
      level_q <= level_d;
      if (wr_valid && !push) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_wr_q    <= 1'b0;
      rd_allowed_q <= 1'b0;
      has_q        <= 1'b0;
      valid_q      <= 1'b0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      ret_q        <= '0;
    end else begin
      rd_allowed_q <= 1'b0;
      if (get_return_data && has_q) has_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (go_rd) begin
            state_q      <= RD_ISSUE;
            rd_allowed_q <= 1'b1;
            last_wr_q    <= 1'b0;
            valid_q      <= 1'b1;
            write_q      <= 1'b0;
            addr_q       <= rd_addr;
          end else if (go_wr) begin
            state_q   <= WR_ISSUE;
            last_wr_q <= 1'b1;
            valid_q   <= 1'b1;
            write_q   <= 1'b1;
            addr_q    <= fa_q[rptr_q];
            wdata_q   <= fd_q[rptr_q];
          end
        end
        WR_ISSUE: begin
          if (mem_cmd_ready) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            write_q <= 1'b0;
          end
        end
        RD_ISSUE: begin
          if (mem_cmd_ready) begin
            state_q <= RD_WAIT;
            valid_q <= 1'b0;
          end
        end
        RD_WAIT: begin
          if (mem_rd_valid) begin
            state_q <= IDLE;
            ret_q   <= mem_rd_data;
            has_q   <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wr_full         = full;
  assign wr_overflow     = ovf_q;
  assign wbuf_level      = level_q;
  assign rd_allowed      = rd_allowed_q;
  assign has_return_data = has_q;
  assign return_data     = ret_q;
  assign mem_cmd_valid   = valid_q;
  assign mem_cmd_write   = write_q;
  assign mem_cmd_addr    = addr_q;
  assign mem_wdata       = wdata_q;
endmodule
